// File: rtl/sort_result_reader.sv
// sort_result_reader
// Read-back engine for the quick-sort register file. After the sorter
// finishes, this block walks indices [lo, hi] through the sorter's
// synchronous read port. Each word is streamed out over valid/ready, and
// out_last marks the final word. A sticky order_err flags any word that is
// smaller (unsigned) than the word before it in the same transfer.
//
// Optional feature: define SORT_READER_CHECKSUM_EN to add the output port
// 'checksum'. It holds the unsigned sum of every word the consumer accepted.
//
// Timing: start sampled at T gives the first out_valid at T+3. A handshake
// at H gives the next out_valid at H+3. After the final handshake, done
// pulses at H+1. An empty range gives done at T+1.
module sort_result_reader #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 10,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] lo,
    input  logic [WORD_SIZE-1:0] hi,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 order_err
`ifdef SORT_READER_CHECKSUM_EN
    ,
    output logic [WORD_SIZE+ADDR_W-1:0] checksum
`endif
);

    localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(DEPTH);
    localparam logic [WORD_SIZE-1:0] LAST_W  = WORD_SIZE'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [ADDR_W-1:0]      index_r, index_s;
    logic [ADDR_W-1:0]      hi_r, hi_s;
    logic [ADDR_W-1:0]      rd_addr_s;
    logic [WORD_SIZE-1:0]   prev_r, prev_s;
    logic [WORD_SIZE-1:0]   out_data_s;
    logic [WORD_SIZE-1:0]   hi_clamp_s;
    logic                   first_r, first_s;
    logic                   rd_en_s;
    logic                   out_valid_s;
    logic                   out_last_s;
    logic                   busy_s;
    logic                   done_s;
    logic                   order_err_s;
`ifdef SORT_READER_CHECKSUM_EN
    logic [WORD_SIZE+ADDR_W-1:0] checksum_s;
`endif

    // Next-state and next-output computation; every registered output is
    // derived from the state being entered, so the outputs come straight
    // from flops.
    always_comb begin
        state_s     = state_r;
        index_s     = index_r;
        hi_s        = hi_r;
        prev_s      = prev_r;
        first_s     = first_r;
        out_data_s  = out_data;
        out_valid_s = out_valid;
        out_last_s  = out_last;
        order_err_s = order_err;
        rd_addr_s   = rd_addr;
`ifdef SORT_READER_CHECKSUM_EN
        checksum_s  = checksum;
`endif
        hi_clamp_s  = (hi >= DEPTH_W) ? LAST_W : hi;

        case (state_r)
            IDLE: begin
                if (start) begin
                    order_err_s = 1'b0;
                    first_s     = 1'b1;
                    hi_s        = hi_clamp_s[ADDR_W-1:0];
`ifdef SORT_READER_CHECKSUM_EN
                    checksum_s  = '0;
`endif
                    if ((lo >= DEPTH_W) || (lo > hi_clamp_s)) begin
                        state_s = DONE;
                    end else begin
                        index_s = lo[ADDR_W-1:0];
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                out_data_s  = rd_data;
                out_valid_s = 1'b1;
                out_last_s  = (index_r == hi_r);
                // The first word has no predecessor, so it cannot be out of order.
                if (!first_r && (rd_data < prev_r)) begin
                    order_err_s = 1'b1;
                end else begin
                    order_err_s = order_err;
                end
                prev_s  = rd_data;
                first_s = 1'b0;
                state_s = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_s = 1'b0;
                    out_last_s  = 1'b0;
`ifdef SORT_READER_CHECKSUM_EN
                    checksum_s  = checksum + {{ADDR_W{1'b0}}, out_data};
`endif
                    if (out_last) begin
                        state_s = DONE;
                    end else begin
                        index_s = index_r + ADDR_W'(1);
                        state_s = READ;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        rd_en_s = (state_s == READ);
        if (state_s == READ) begin
            rd_addr_s = index_s;
        end else begin
            rd_addr_s = rd_addr;
        end
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State and output registers; synchronous reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            index_r   <= '0;
            hi_r      <= '0;
            prev_r    <= '0;
            first_r   <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            order_err <= 1'b0;
`ifdef SORT_READER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            hi_r      <= hi_s;
            prev_r    <= prev_s;
            first_r   <= first_s;
            rd_en     <= rd_en_s;
            rd_addr   <= rd_addr_s;
            out_data  <= out_data_s;
            out_valid <= out_valid_s;
            out_last  <= out_last_s;
            busy      <= busy_s;
            done      <= done_s;
            order_err <= order_err_s;
`ifdef SORT_READER_CHECKSUM_EN
            checksum  <= checksum_s;
`endif
        end
    end

endmodule

// File: doc/sort_result_reader.md
Name: sort_result_reader

Overview:
- Read-back engine for the quick-sort register file. Once the sorter finishes, it walks indices lo..hi of the sorted array through the sorter's synchronous read port.
- It streams each word out over a valid/ready interface, with a last marker on the final word.
- It checks that the stream is non-decreasing (unsigned) and raises a sticky flag if not.
- Sits between quick_sort and the downstream consumer or test harness.

Parameters:
- WORD_SIZE, 16, width of each array element and of lo/hi as the sorter sees them.
- DEPTH, 10, number of entries in the sorter's register array.
- ADDR_W, 4, width of rd_addr; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin read-back of [lo, hi]
- lo  in  WORD_SIZE  first index, sampled on start
- hi  in  WORD_SIZE  last index, sampled on start
- rd_en  out  1  read strobe to sorter array
- rd_addr  out  ADDR_W  read index
- rd_data  in  WORD_SIZE  array word; valid exactly one cycle after rd_en
- out_data  out  WORD_SIZE  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_last  out  1  qualifies the final word; meaningful only with out_valid
- busy  out  1  high from the cycle after start until done deasserts
- done  out  1  one-cycle completion pulse
- order_err  out  1  sticky ordering violation, cleared on accepted start

Behaviour:
- Reset, clock and polarity: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state IDLE; rd_en, out_valid, out_last, busy, done and order_err all 0; rd_addr 0; out_data 0; internal prev-word register 0.
- Reset during any state aborts the transfer in the same edge. No further valid or done is produced.
- FSM states: IDLE, READ, CAPTURE, HOLD, DONE.
- IDLE, start=1:
  - Latch lo and hi, and clear order_err.
  - Clamp hi to DEPTH-1 when hi >= DEPTH.
  - If lo > clamped hi, or lo >= DEPTH, the range is empty: go to DONE.
  - Otherwise load the index counter with lo and go to READ.
- start is ignored in every state except IDLE.
- READ: rd_en=1, rd_addr=index; go to CAPTURE.
- CAPTURE:
  - Register rd_data into out_data.
  - Set out_valid=1 and out_last=(index==hi); go to HOLD.
  - Compare the word with the prev-word register, unsigned. If the word is smaller and it is not the first word of the transfer, set order_err=1.
  - Update the prev-word register.
- HOLD:
  - out_data, out_valid and out_last stay stable while out_ready=0.
  - On out_valid && out_ready: drop out_valid and out_last. If out_last, go to DONE; else increment index and go to READ.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE.
- Latency: start sampled at cycle T gives first out_valid at T+3.
- Throughput: a handshake at H gives the next out_valid at H+3, i.e. one word per 3 cycles at best.
- Last handshake at H gives done at H+1. Empty range gives done at T+1 with no out_valid.
- The index counter never exceeds DEPTH-1. Single-element range (lo==hi) emits one word with out_last=1.

Optional Feature:
- Macro: SORT_READER_CHECKSUM_EN
- When defined:
  - Adds output checksum, width WORD_SIZE+ADDR_W, cleared on accepted start.
  - Each word accepted by the consumer is added to checksum, unsigned with no wrap within range.
  - checksum is stable from the done pulse until the next accepted start or rst. Reset value is 0.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- Sorted array {1,2,5,6,8,13,22,33,34,55}, lo=0, hi=9, out_ready=1 -> 10 words in that order; out_last only on 55; done at handshake+1; order_err=0; first out_valid 3 cycles after start; checksum=179 when enabled.
- Unsorted array {55,8,34,6,5,22,33,2,1,13}, lo=0, hi=9 -> words in array order; order_err=1 from the cycle 8 is captured; still 10 words; done pulses.
- Sorted array, out_ready toggled 0/1 every other cycle plus 4 stalled cycles on word 13 -> out_data and out_last held stable while stalled; no word lost or duplicated.
- lo=3, hi=3 -> single word 6 with out_last=1; done one cycle after its handshake. lo=5, hi=2 -> done at T+1, out_valid never asserted, busy high exactly one cycle.
- hi=15, lo=8 -> clamped to hi=9: words 34 then 55, last on 55. Assert start again while busy -> ignored.
- rst high while HOLD on word 4 -> next edge: out_valid=0, busy=0, order_err=0, no done; a following start with lo=0, hi=9 replays all 10 words correctly.
